// File: rtl/cache_request_arbiter.sv
// Arbitrates fill, store and round-robin load requesters onto one cache request
// port through a single registered output stage with valid/ready handshakes.
package cache_request_arbiter_pkg;

    localparam int unsigned REQ_W = 104;

    localparam logic [31:0] REQ_TYPE_READ      = 32'd0;
    localparam logic [31:0] REQ_TYPE_WRITE     = 32'd1;
    localparam logic [31:0] REQ_TYPE_DRAM_FILL = 32'd2;

    typedef struct packed {
        logic [5:0]  index;
        logic [3:0]  block_offset;
        logic [21:0] tag;
        logic [31:0] write_data;
        logic [31:0] request_type;
        logic        is_valid;
        logic [3:0]  write_enable;
        logic [2:0]  write_set;
    } cache_req_t;

endpackage

module cache_request_arbiter
    import cache_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_READ_PORTS   = 2,
    parameter int unsigned WRITE_STREAK_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fill_valid,
    input  logic [REQ_W-1:0]                  fill_request,
    output logic                              fill_ready,
    input  logic                              write_valid,
    input  logic [REQ_W-1:0]                  write_request,
    output logic                              write_ready,
    input  logic [NUM_READ_PORTS-1:0]         read_valid,
    input  logic [NUM_READ_PORTS*REQ_W-1:0]   read_request,
    output logic [NUM_READ_PORTS-1:0]         read_ready,
    output logic                              out_valid,
    output logic [REQ_W-1:0]                  out_request,
    input  logic                              out_ready
);

    localparam int unsigned PTR_W    = 2;
    localparam int unsigned STREAK_W = 4;

    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [STREAK_W-1:0]       write_streak_q, write_streak_d;
    logic                      out_valid_q, out_valid_d;
    cache_req_t                out_request_q, out_request_d;

    logic                      can_load;
    logic                      any_read;
    logic                      streak_full;
    logic                      grant_fill, grant_write, grant_read, grant_any;
    logic                      load_en;
    logic                      rr_found;
    logic [PTR_W:0]            rr_sum;
    logic [PTR_W:0]            rr_next;
    logic [PTR_W-1:0]          read_idx;
    logic [NUM_READ_PORTS-1:0] read_sel;
    cache_req_t                read_req_sel;
    cache_req_t                load_req;

    assign can_load    = !out_valid_q || out_ready;
    assign any_read    = |read_valid;
    assign streak_full = (write_streak_q == STREAK_W'(WRITE_STREAK_MAX));

    // Fixed priority on top, streak limit lets a waiting load past the store port.
    assign grant_fill  = fill_valid;
    assign grant_write = !fill_valid && write_valid && !(streak_full && any_read);
    assign grant_read  = !fill_valid && !grant_write && any_read;
    assign grant_any   = grant_fill || grant_write || grant_read;
    assign load_en     = grant_any && can_load;

    // Round-robin search from rr_ptr, ascending with wrap.
    always_comb begin
        rr_found     = 1'b0;
        rr_sum       = '0;
        read_idx     = '0;
        read_sel     = '0;
        read_req_sel = '0;
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (rr_sum >= (PTR_W+1)'(NUM_READ_PORTS)) begin
                rr_sum = rr_sum - (PTR_W+1)'(NUM_READ_PORTS);
            end
            for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
                if (!rr_found && (rr_sum == (PTR_W+1)'(p)) && read_valid[p]) begin
                    rr_found    = 1'b1;
                    read_sel[p] = 1'b1;
                    read_idx    = PTR_W'(p);
                end
            end
        end
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            if (read_sel[p]) begin
                read_req_sel = cache_req_t'(read_request[p*REQ_W +: REQ_W]);
            end
        end
    end

    assign rr_next = {1'b0, read_idx} + (PTR_W+1)'(1);

    // Field rewrite of the granted request.
    always_comb begin
        load_req = '0;
        if (grant_fill) begin
            load_req              = cache_req_t'(fill_request);
            load_req.request_type = REQ_TYPE_DRAM_FILL;
        end else if (grant_write) begin
            load_req              = cache_req_t'(write_request);
            load_req.request_type = REQ_TYPE_WRITE;
        end else begin
            load_req              = read_req_sel;
            load_req.request_type = REQ_TYPE_READ;
            load_req.write_enable = 4'h0;
        end
        load_req.is_valid = 1'b1;
    end

    // Next-state for output stage, round-robin pointer and write streak.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_request_d  = out_request_q;
        rr_ptr_d       = rr_ptr_q;
        write_streak_d = write_streak_q;

        if (load_en) begin
            out_valid_d   = 1'b1;
            out_request_d = load_req;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end

        if (can_load) begin
            if (grant_read) begin
                rr_ptr_d = (rr_next == (PTR_W+1)'(NUM_READ_PORTS)) ? '0 : PTR_W'(rr_next);
            end
            if (!any_read || grant_read) begin
                write_streak_d = '0;
            end else if (grant_write && !streak_full) begin
                write_streak_d = write_streak_q + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_request_q  <= '0;
            rr_ptr_q       <= '0;
            write_streak_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_request_q  <= out_request_d;
            rr_ptr_q       <= rr_ptr_d;
            write_streak_q <= write_streak_d;
        end
    end

    // Readies are held low while reset is asserted.
    assign fill_ready  = rst_n && grant_fill && can_load;
    assign write_ready = rst_n && grant_write && can_load;
    assign read_ready  = {NUM_READ_PORTS{rst_n && grant_read && can_load}} & read_sel;

    assign out_valid   = out_valid_q;
    assign out_request = out_request_q;

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed bench for cache_request_arbiter: reset, rewrite, priority, streak
// limit, round-robin and backpressure with hand-computed expectations.
module tb_cache_request_arbiter;
    import cache_request_arbiter_pkg::*;

    logic           clk;
    logic           rst_n = 1'b0;
    logic           fill_valid = 1'b0;
    logic [103:0]   fill_request = '0;
    logic           fill_ready;
    logic           write_valid = 1'b0;
    logic [103:0]   write_request = '0;
    logic           write_ready;
    logic [1:0]     read_valid = 2'b00;
    logic [207:0]   read_request = '0;
    logic [1:0]     read_ready;
    logic           out_valid;
    logic [103:0]   out_request;
    logic           out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    cache_request_arbiter #(.NUM_READ_PORTS(2), .WRITE_STREAK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_valid(fill_valid), .fill_request(fill_request), .fill_ready(fill_ready),
        .write_valid(write_valid), .write_request(write_request), .write_ready(write_ready),
        .read_valid(read_valid), .read_request(read_request), .read_ready(read_ready),
        .out_valid(out_valid), .out_request(out_request), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic cache_req_t mk(input logic [5:0] idx, input logic [3:0] we);
        cache_req_t r;
        r              = '0;
        r.index        = idx;
        r.block_offset = 4'h3;
        r.tag          = 22'h1ABC00 | {16'h0, idx};
        r.write_data   = 32'hC0DE_0000 | {26'h0, idx};
        r.request_type = 32'h7;
        r.is_valid     = 1'b0;
        r.write_enable = we;
        r.write_set    = 3'h5;
        return r;
    endfunction

    // Expected cache-side form of a request after the arbiter rewrites it.
    function automatic cache_req_t rw(input cache_req_t r, input logic [31:0] t, input logic clr_we);
        cache_req_t e;
        e              = r;
        e.request_type = t;
        e.is_valid     = 1'b1;
        if (clr_we) e.write_enable = 4'h0;
        return e;
    endfunction

    task automatic test_reset();
        cache_req_t exp_r;
        logic [3:0] vec;
        fill_valid   = 1'b1;
        write_valid  = 1'b1;
        read_valid   = 2'b11;
        out_ready    = 1'b1;
        fill_request = mk(6'h11, 4'h1);
        repeat (2) @(posedge clk);
        #1;
        vec = {fill_ready, write_ready, read_ready};
        checks++;
        if (vec !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", vec); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_request !== 104'h0) begin errors++; $display("FAIL reset_out_request: got %h expected 0", out_request); end
        checks++;
        if (dut.rr_ptr_q !== 2'd0 || dut.write_streak_q !== 4'd0) begin
            errors++; $display("FAIL reset_state: rr=%0d streak=%0d expected 0 0", dut.rr_ptr_q, dut.write_streak_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vec = {fill_ready, write_ready, read_ready};
        checks++;
        if (vec !== 4'b1000) begin errors++; $display("FAIL release_fill_ready: got %b expected 1000", vec); end
        @(posedge clk); #1;
        exp_r = rw(mk(6'h11, 4'h1), 32'd2, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_request !== exp_r) begin
            errors++; $display("FAIL release_fill_out: valid=%b req=%h expected 1 %h", out_valid, out_request, exp_r);
        end
        @(negedge clk);
        fill_valid  = 1'b0;
        write_valid = 1'b0;
        read_valid  = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_after_release: got %b expected 0", out_valid); end
    endtask

    task automatic test_single_read();
        cache_req_t exp_r;
        logic [3:0] vec;
        @(negedge clk);
        read_request[0 +: 104] = mk(6'h2A, 4'hF);
        read_valid = 2'b01;
        #1;
        vec = {fill_ready, write_ready, read_ready};
        checks++;
        if (vec !== 4'b0001) begin errors++; $display("FAIL single_read_ready: got %b expected 0001", vec); end
        @(posedge clk); #1;
        exp_r = rw(mk(6'h2A, 4'hF), 32'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_request !== exp_r) begin
            errors++; $display("FAIL single_read_out: valid=%b req=%h expected 1 %h", out_valid, out_request, exp_r);
        end
        @(negedge clk);
        read_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_request !== exp_r) begin
            errors++; $display("FAIL single_read_drain: valid=%b req=%h expected 0 %h", out_valid, out_request, exp_r);
        end
    endtask

    task automatic test_priority();
        cache_req_t exp_r;
        logic [3:0] vec;
        @(negedge clk);
        fill_request           = mk(6'h01, 4'h2);
        write_request          = mk(6'h02, 4'hA);
        read_request[0 +: 104] = mk(6'h03, 4'h9);
        fill_valid  = 1'b1;
        write_valid = 1'b1;
        read_valid  = 2'b01;
        #1;
        vec = {fill_ready, write_ready, read_ready};
        checks++;
        if (vec !== 4'b1000) begin errors++; $display("FAIL prio_fill_ready: got %b expected 1000", vec); end
        @(posedge clk); #1;
        exp_r = rw(mk(6'h01, 4'h2), 32'd2, 1'b0);
        checks++;
        if (out_request !== exp_r) begin errors++; $display("FAIL prio_fill_out: got %h expected %h", out_request, exp_r); end
        @(negedge clk);
        fill_valid = 1'b0;
        #1;
        vec = {fill_ready, write_ready, read_ready};
        checks++;
        if (vec !== 4'b0100) begin errors++; $display("FAIL prio_write_ready: got %b expected 0100", vec); end
        @(posedge clk); #1;
        exp_r = rw(mk(6'h02, 4'hA), 32'd1, 1'b0);
        checks++;
        if (out_request !== exp_r) begin errors++; $display("FAIL prio_write_out: got %h expected %h", out_request, exp_r); end
        @(negedge clk);
        write_valid = 1'b0;
        #1;
        vec = {fill_ready, write_ready, read_ready};
        checks++;
        if (vec !== 4'b0001) begin errors++; $display("FAIL prio_read_ready: got %b expected 0001", vec); end
        @(posedge clk); #1;
        exp_r = rw(mk(6'h03, 4'h9), 32'd0, 1'b1);
        checks++;
        if (out_request !== exp_r) begin errors++; $display("FAIL prio_read_out: got %h expected %h", out_request, exp_r); end
        @(negedge clk);
        read_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_write_streak();
        logic [3:0] exp_vec [10];
        logic [3:0] exp_stk [10];
        logic [3:0] vec;
        exp_vec = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001,
                    4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        exp_stk = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        @(negedge clk);
        write_request          = mk(6'h04, 4'h3);
        read_request[0 +: 104] = mk(6'h05, 4'h6);
        write_valid = 1'b1;
        read_valid  = 2'b01;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            vec = {fill_ready, write_ready, read_ready};
            checks++;
            if (vec !== exp_vec[i]) begin errors++; $display("FAIL streak_grant[%0d]: got %b expected %b", i, vec, exp_vec[i]); end
            @(posedge clk); #1;
            checks++;
            if (dut.write_streak_q !== exp_stk[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL streak_state[%0d]: streak=%0d valid=%b expected %0d 1", i, dut.write_streak_q, out_valid, exp_stk[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_vec [5];
        logic [5:0] exp_idx [5];
        logic [3:0] vec;
        cache_req_t got;
        exp_vec = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
        exp_idx = '{6'h01, 6'h02, 6'h03, 6'h01, 6'h02};
        // Reset with a request still held in the output stage.
        @(negedge clk);
        rst_n       = 1'b0;
        write_valid = 1'b0;
        read_valid  = 2'b00;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
            errors++; $display("FAIL midreset: valid=%b rr=%0d expected 0 0", out_valid, dut.rr_ptr_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_request[0 +: 104]   = mk(6'h01, 4'h1);
        read_request[104 +: 104] = mk(6'h02, 4'h2);
        fill_request             = mk(6'h03, 4'h3);
        read_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            fill_valid = (i == 2);
            #1;
            vec = {fill_ready, write_ready, read_ready};
            checks++;
            if (vec !== exp_vec[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, vec, exp_vec[i]); end
            @(posedge clk); #1;
            got = cache_req_t'(out_request);
            checks++;
            if (got.index !== exp_idx[i]) begin errors++; $display("FAIL rr_out[%0d]: index=%h expected %h", i, got.index, exp_idx[i]); end
        end
        @(negedge clk);
        fill_valid = 1'b0;
        read_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        cache_req_t exp_a, exp_b;
        @(negedge clk);
        read_request[0 +: 104] = mk(6'h05, 4'h4);
        read_valid = 2'b01;
        out_ready  = 1'b1;
        #1;
        checks++;
        if (read_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready: got %b expected 01", read_ready); end
        @(posedge clk); #1;
        exp_a = rw(mk(6'h05, 4'h4), 32'd0, 1'b1);
        exp_b = rw(mk(6'h09, 4'h8), 32'd0, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        read_request[0 +: 104] = mk(6'h09, 4'h8);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            checks++;
            if (read_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, read_ready); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_request !== exp_a || dut.rr_ptr_q !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b req=%h rr=%0d expected 1 %h 1", i, out_valid, out_request, dut.rr_ptr_q, exp_a);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (read_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready: got %b expected 01", read_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_request !== exp_b) begin
            errors++; $display("FAIL bp_release_out: valid=%b req=%h expected 1 %h", out_valid, out_request, exp_b);
        end
        @(negedge clk);
        read_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_request !== exp_b) begin
            errors++; $display("FAIL bp_drain: valid=%b req=%h expected 0 %h", out_valid, out_request, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_write_streak();
        test_round_robin();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
